// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control
// Purpose  : Main control FSM of a multicycle MIPS-style datapath. Sequences
//            fetch, decode and the per-class execute/memory/writeback states,
//            and drives write enables, mux selects and the ALU decoder class.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
  parameter bit HAS_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       memto_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  // Supported opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t     r_state;
  logic       w_ready;
  logic       w_legal;
  logic       w_pc_en;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

  // Without a ready handshake every memory access completes in one cycle
  assign w_ready = HAS_MEM_READY ? mem_ready : 1'b1;

  // Opcodes that DECODE knows how to dispatch
  assign w_legal = (opcode == OP_LW)   || (opcode == OP_SW)   ||
                   (opcode == OP_RTYPE)|| (opcode == OP_BEQ)  ||
                   (opcode == OP_BNE)  || (opcode == OP_ADDI) ||
                   (opcode == OP_J);

  // State register and transition rules; unused encodings fall back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:   r_state <= S_MEMADR;
            OP_RTYPE:       r_state <= S_EXEC;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_ADDI:        r_state <= S_ADDIEX;
            OP_J:           r_state <= S_JUMP;
            default:        r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_LW)      r_state <= S_MEMRD;
          else if (opcode == OP_SW) r_state <= S_MEMWR;
          else                      r_state <= S_FETCH;
        end
        S_MEMRD: begin
          if (w_ready) r_state <= S_MEMWB;
        end
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR: begin
          if (w_ready) r_state <= S_FETCH;
        end
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the registered state. The FETCH enables and the
  // branch pc_en follow mem_ready/zero within the same cycle, so these are
  // decoded rather than registered to avoid a cycle of lag on the handshake.
  always_comb begin
    w_pc_en     = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    memto_reg   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        w_ir_write = w_ready;
        w_pc_en    = w_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        w_illegal = ~w_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memto_reg   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        w_pc_en   = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        w_pc_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Enables are forced low while reset is held, independent of mem_ready
  assign pc_en      = w_pc_en     & rst_n;
  assign ir_write   = w_ir_write  & rst_n;
  assign mem_write  = w_mem_write & rst_n;
  assign reg_write  = w_reg_write & rst_n;
  assign illegal_op = w_illegal   & rst_n;
  assign state      = r_state;

endmodule

`default_nettype wire
